// File: rtl/stream_pkg.sv
// Shared definitions for the stream packing stage: default packing ratio and the lane-keep mask helper.
package stream_pkg;

    localparam int RATIO_DEFAULT = 2;
    localparam int MASK_W        = 32;

    // Lanes 0..count-1 are kept; a count at or above ratio marks every lane of a full beat.
    function automatic logic [MASK_W-1:0] keep_mask(input int unsigned count, input int unsigned ratio);
        int unsigned lanes;
        lanes = (count >= ratio) ? ratio : count;
        if (lanes >= MASK_W)
            keep_mask = '1;
        else
            keep_mask = (MASK_W'(1) << lanes) - MASK_W'(1);
    endfunction

endpackage

// File: rtl/stream_word_packer.sv
// Packs RATIO consecutive DATA_WIDTH-bit words into one wide beat; a flush emits a partial beat with a keep mask.
module stream_word_packer
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RATIO      = RATIO_DEFAULT
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_valid_s,
    output logic                        o_ready_s,
    input  logic [DATA_WIDTH-1:0]       i_datain,
    input  logic                        i_flush,
    output logic                        o_valid_m,
    input  logic                        i_ready_m,
    output logic [DATA_WIDTH*RATIO-1:0] o_dataout,
    output logic [RATIO-1:0]            o_keep,
    output logic                        o_pending
);

    localparam int              IDX_W    = $clog2(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    logic [DATA_WIDTH-1:0]       acc [RATIO];
    logic [IDX_W-1:0]            idx;
    logic                        flush_pend;
    logic                        slot_free;
    logic                        acc_en;
    logic                        flush_req;
    logic [IDX_W:0]              fill_cnt;
    logic [DATA_WIDTH*RATIO-1:0] beat_next;
    logic [RATIO-1:0]            keep_next;

    assign slot_free = ~o_valid_m | i_ready_m;
    assign o_ready_s = slot_free & ~flush_pend & ~i_rst;
    assign acc_en    = i_valid_s & o_ready_s;
    assign flush_req = i_flush | flush_pend;
    assign o_pending = (idx != '0);

    // A word accepted on the same edge as a flush or completion joins the outgoing beat.
    assign fill_cnt  = {1'b0, idx} + {{IDX_W{1'b0}}, acc_en};
    assign keep_next = RATIO'(keep_mask(32'(fill_cnt), 32'(RATIO)));

    always_comb begin
        beat_next = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (IDX_W'(k) < idx)
                beat_next[k*DATA_WIDTH +: DATA_WIDTH] = acc[k];
            else if ((IDX_W'(k) == idx) && acc_en)
                beat_next[k*DATA_WIDTH +: DATA_WIDTH] = i_datain;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx        <= '0;
            flush_pend <= 1'b0;
            o_valid_m  <= 1'b0;
            o_dataout  <= '0;
            o_keep     <= '0;
            for (int k = 0; k < RATIO; k++)
                acc[k] <= '0;
        end else begin
            if (o_valid_m && i_ready_m)
                o_valid_m <= 1'b0;

            if (acc_en) begin
                acc[idx] <= i_datain;
                if ((idx == LAST_IDX) || i_flush) begin
                    o_dataout  <= beat_next;
                    o_keep     <= keep_next;
                    o_valid_m  <= 1'b1;
                    idx        <= '0;
                    flush_pend <= 1'b0;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end else if (flush_req) begin
                // Flushing an empty accumulator is dropped; otherwise wait for the output slot.
                if (idx == '0) begin
                    flush_pend <= 1'b0;
                end else if (slot_free) begin
                    o_dataout  <= beat_next;
                    o_keep     <= keep_next;
                    o_valid_m  <= 1'b1;
                    idx        <= '0;
                    flush_pend <= 1'b0;
                end else begin
                    flush_pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_word_packer.sv
// Self-checking bench for stream_word_packer: directed scenarios plus a randomized source against a queue-based model.
module tb_stream_word_packer;

    localparam int DW    = 32;
    localparam int RATIO = 4;
    localparam int BW    = DW * RATIO;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_valid_s;
    logic          o_ready_s;
    logic [DW-1:0] i_datain;
    logic          i_flush;
    logic          o_valid_m;
    logic          i_ready_m;
    logic [BW-1:0] o_dataout;
    logic [RATIO-1:0] o_keep;
    logic          o_pending;

    int check_count = 0;
    int pass_count  = 0;

    // Reference model: stored words as a queue, plus the presented beat.
    logic [DW-1:0]    m_words [$];
    logic             m_valid;
    logic             m_flush_pend;
    logic [BW-1:0]    m_data;
    logic [RATIO-1:0] m_keep;

    logic [DW-1:0] sent_words [$];
    logic [DW-1:0] got_words  [$];
    logic [DW-1:0] src        [$];

    stream_word_packer #(
        .DATA_WIDTH(DW),
        .RATIO     (RATIO)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid_s(i_valid_s),
        .o_ready_s(o_ready_s),
        .i_datain (i_datain),
        .i_flush  (i_flush),
        .o_valid_m(o_valid_m),
        .i_ready_m(i_ready_m),
        .o_dataout(o_dataout),
        .o_keep   (o_keep),
        .o_pending(o_pending)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [BW-1:0] observed, input logic [BW-1:0] expected);
        check_count++;
        if (observed === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    endtask

    task automatic modelEmit();
        m_data = '0;
        for (int k = 0; k < m_words.size(); k++)
            m_data[k*DW +: DW] = m_words[k];
        m_keep       = RATIO'((1 << m_words.size()) - 1);
        m_valid      = 1'b1;
        m_flush_pend = 1'b0;
        m_words.delete();
    endtask

    task automatic checkRegistered();
        checkOutput("valid_m", BW'(o_valid_m), BW'(m_valid));
        checkOutput("dataout", o_dataout, m_data);
        checkOutput("keep",    BW'(o_keep),    BW'(m_keep));
        checkOutput("pending", BW'(o_pending), BW'(m_words.size() != 0));
    endtask

    task automatic applyReset();
        i_rst     = 1'b1;
        i_valid_s = 1'b1;
        i_datain  = 32'hDEADBEEF;
        i_flush   = 1'b0;
        i_ready_m = 1'b0;
        #1;
        checkOutput("ready_in_reset", BW'(o_ready_s), BW'(0));
        @(posedge i_clk);
        #1;
        i_rst        = 1'b0;
        i_valid_s    = 1'b0;
        m_words.delete();
        m_valid      = 1'b0;
        m_flush_pend = 1'b0;
        m_data       = '0;
        m_keep       = '0;
        checkRegistered();
    endtask

    // One clock cycle: drive inputs, check ready, advance the model, then check registered outputs.
    task automatic applyStimulus(input logic valid, input logic [DW-1:0] data, input logic flush,
                                 input logic ready_m, output logic accepted);
        logic slot_free;
        logic exp_ready;
        i_valid_s = valid;
        i_datain  = data;
        i_flush   = flush;
        i_ready_m = ready_m;
        #1;
        slot_free = !m_valid || ready_m;
        exp_ready = slot_free && !m_flush_pend;
        accepted  = valid && exp_ready;
        checkOutput("ready_s", BW'(o_ready_s), BW'(exp_ready));

        if (o_valid_m && ready_m)
            for (int k = 0; k < RATIO; k++)
                if (o_keep[k]) got_words.push_back(o_dataout[k*DW +: DW]);
        if (accepted)
            sent_words.push_back(data);

        if (m_valid && ready_m)
            m_valid = 1'b0;
        if (accepted) begin
            m_words.push_back(data);
            if (m_words.size() == RATIO || flush)
                modelEmit();
        end else if (flush || m_flush_pend) begin
            if (m_words.size() == 0)
                m_flush_pend = 1'b0;
            else if (slot_free)
                modelEmit();
            else
                m_flush_pend = 1'b1;
        end

        @(posedge i_clk);
        #1;
        checkRegistered();
    endtask

    initial begin
        logic took;
        int   cycles;

        applyReset();

        // Full beat with a ready sink
        applyStimulus(1'b1, 32'h11111111, 1'b0, 1'b1, took);
        applyStimulus(1'b1, 32'h22222222, 1'b0, 1'b1, took);
        applyStimulus(1'b1, 32'h33333333, 1'b0, 1'b1, took);
        applyStimulus(1'b1, 32'h44444444, 1'b0, 1'b1, took);
        checkOutput("full_beat_data", o_dataout, 128'h44444444_33333333_22222222_11111111);
        checkOutput("full_beat_keep", BW'(o_keep), BW'(4'hF));
        applyStimulus(1'b0, '0, 1'b0, 1'b1, took);

        // Partial flush of two words
        applyStimulus(1'b1, 32'h0000000A, 1'b0, 1'b1, took);
        applyStimulus(1'b1, 32'h0000000B, 1'b0, 1'b1, took);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, took);
        checkOutput("partial_data", o_dataout, 128'h00000000_00000000_0000000B_0000000A);
        checkOutput("partial_keep", BW'(o_keep), BW'(4'b0011));
        checkOutput("partial_pending", BW'(o_pending), BW'(0));
        applyStimulus(1'b0, '0, 1'b0, 1'b1, took);

        // Flush on an empty accumulator produces nothing
        applyStimulus(1'b0, '0, 1'b1, 1'b1, took);
        checkOutput("empty_flush_valid", BW'(o_valid_m), BW'(0));

        // Flush together with the completing word yields one full beat only
        applyStimulus(1'b1, 32'h00000001, 1'b0, 1'b1, took);
        applyStimulus(1'b1, 32'h00000002, 1'b0, 1'b1, took);
        applyStimulus(1'b1, 32'h00000003, 1'b0, 1'b1, took);
        applyStimulus(1'b1, 32'h00000004, 1'b1, 1'b1, took);
        checkOutput("flush_full_keep", BW'(o_keep), BW'(4'hF));
        applyStimulus(1'b0, '0, 1'b0, 1'b1, took);
        checkOutput("flush_full_no_extra", BW'(o_valid_m), BW'(0));

        // Flush on the same cycle as a single accept keeps just that lane
        applyStimulus(1'b1, 32'hCAFE0001, 1'b1, 1'b1, took);
        checkOutput("flush_accept_keep", BW'(o_keep), BW'(4'b0001));

        // Back-pressure: beat held, input blocked, then released in order
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 32'hB0000000 + DW'(i), 1'b0, 1'b0, took);
        checkOutput("stall_ready", BW'(o_ready_s), BW'(0));
        applyStimulus(1'b0, '0, 1'b1, 1'b0, took);
        for (int i = 4; i < 8; i++)
            applyStimulus(1'b1, 32'hB0000000 + DW'(i), 1'b0, 1'b1, took);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, took);

        // Reset with a stored word, and with a stalled beat
        applyStimulus(1'b1, 32'h5EA1_0001, 1'b0, 1'b1, took);
        applyReset();
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 32'h5EA1_0010 + DW'(i), 1'b0, 1'b0, took);
        applyReset();
        applyStimulus(1'b1, 32'h0000C001, 1'b0, 1'b1, took);
        applyStimulus(1'b1, 32'h0000C002, 1'b0, 1'b1, took);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, took);
        checkOutput("fresh_beat_data", o_dataout, 128'h00000000_00000000_0000C002_0000C001);

        // Randomized FIFO-like source with random sink readiness and flushes
        applyStimulus(1'b0, '0, 1'b0, 1'b1, took);
        sent_words.delete();
        got_words.delete();
        for (int i = 0; i < 60; i++)
            src.push_back($urandom);
        cycles = 0;
        while (src.size() > 0 && cycles < 2000) begin
            applyStimulus($urandom_range(0, 3) != 0, src[0], $urandom_range(0, 15) == 0,
                          $urandom_range(0, 2) != 0, took);
            if (took)
                void'(src.pop_front());
            cycles++;
        end
        checkOutput("source_drained", BW'(src.size()), BW'(0));
        applyStimulus(1'b0, '0, 1'b1, 1'b1, took);
        repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b1, took);

        checkOutput("word_count", BW'(got_words.size()), BW'(sent_words.size()));
        for (int i = 0; i < sent_words.size() && i < got_words.size(); i++)
            checkOutput("word_order", BW'(got_words[i]), BW'(sent_words[i]));

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
